trail_access_ctrl: RTL and testbench
====================================

// Module: trail_access_ctrl
// PURPOSE
//  Sole master of the trail manager's push and backtrack ports. Arbitrates assignment pushes from
//  NUM_REQ requesters (BCP units, decision unit) and owns the authoritative decision-level counter.
//  Sequences backtrack: issues the request, forwards each undone assignment on a clear stream, then
//  acknowledges. Pushes are never accepted while a backtrack is in flight.
// PARAMETERS
//  NUM_REQ   2    push requesters; index 0 has highest fixed priority
//  MAX_VARS  256  trail capacity; must match the trail manager instance
//  LVL_W     16   decision-level / reason width
// PORTS
//  clk                   in   1              clock, rising edge
//  reset_n               in   1              asynchronous, active-low reset
//  req_valid             in   NUM_REQ        push request per requester
//  req_ready             out  NUM_REQ        one-hot grant; a transfer is valid&&ready
//  req_var               in   NUM_REQ x 32   variable id
//  req_value             in   NUM_REQ        polarity
//  req_is_decision       in   NUM_REQ        1 = decision (opens a new level)
//  req_reason            in   NUM_REQ x LVL_W  reason clause id (ignored for decisions)
//  bt_req_valid/_ready   in/out 1            backtrack handshake
//  bt_req_level          in   LVL_W          target level
//  bt_done               out  1              1-cycle pulse: backtrack complete
//  clr_valid/var/value   out  1/32/1         one undone assignment per cycle
//  clear_all             in   1              synchronous flush of solver state
//  level                 out  LVL_W          current decision level (level_q)
//  busy, trail_full      out  1/1            backtrack in flight / tm_height==MAX_VARS
//  tm_push, tm_push_var, tm_push_value, tm_push_level, tm_push_is_decision, tm_push_reason  out
//  tm_backtrack_en/_to_level  out  1/LVL_W   trail backtrack command
//  tm_backtrack_valid/var/value/done  in     trail drain stream and completion pulse
//  tm_height             in   16             registered trail height
//  tm_clear_all          out  1              combinational copy of clear_all
// BEHAVIOUR
//  - Reset: state=RUN, level_q=0, all outputs 0 (req_ready=0, bt_req_ready=0, tm_*=0, busy=0).
//  - FSM: RUN -> BT_ISSUE -> BT_DRAIN -> BT_DONE -> RUN.
//  - RUN, grant: not full, bt_req_valid=0, and level_q!=2^LVL_W-1 for decisions. Lowest valid
//    index wins, except a decision is granted only if no non-decision request is valid.
//    Grant is combinational; tm_push in the same cycle; <=1 push/cycle.
//  - Push level: propagation -> level_q; decision -> level_q+1, level_q<=level_q+1 at edge.
//  - Full: tm_height>=MAX_VARS -> req_ready=0 (requests held, never dropped); trail_full=1.
//  - RUN, bt_req_valid: bt_req_ready=1 (1 cycle); beats pushes in the same cycle.
//    bt_req_level>=level_q -> no-op: bt_done pulses next cycle, level unchanged, stays RUN.
//    else latch target, -> BT_ISSUE.
//  - BT_ISSUE: tm_backtrack_en=1 one cycle, tm_backtrack_to_level=target -> BT_DRAIN.
//  - BT_DRAIN: clr_valid/var/value = tm_backtrack_* (combinational, 0 latency);
//    tm_backtrack_done -> BT_DONE.
//  - BT_DONE: level_q<=target, bt_done=1, -> RUN. Grants resume the following cycle;
//    this guarantees tm_height is settled before the next push.
//  - busy=1 in BT_ISSUE/BT_DRAIN/BT_DONE; req_ready=0 and bt_req_ready=0 while busy.
//  - clear_all (any state, highest priority): level_q<=0, state<=RUN, no grant or bt_done
//    that cycle; a drain in progress is abandoned.
//  - Async reset mid-backtrack: immediate return to reset values; no bt_done is emitted.
// STRUCTURE
//  - sat_pkg: trail_push_t {var, value, level, is_decision, reason}, LVL_W, ctrl_state_t enum.
//  - Sub-module prio_dec_arb: fixed-priority grant with decision masking. The rest is one FSM
//    plus level register; ~200 lines total.
// TESTING
//  1. Req0 prop var5 and req1 decision var9 same cycle, level 0 -> var5 pushed @lvl0, then
//     var9 @lvl1; level=1.
//  2. Decisions on vars 1,2,3, props 4@3, bt_req_level=1 -> tm_backtrack_en 1 cycle later;
//     clr stream 4,3,2; bt_done; level=1.
//  3. bt_req_level=3 while level=2 -> bt_done next cycle, no tm_backtrack_en, level stays 2.
//  4. Fill to tm_height=256 -> req_ready=0 and trail_full=1; after backtrack frees entries the
//     held request is granted.
//  5. bt_req_valid and req_valid same cycle -> bt accepted, no tm_push; the push waits until
//     the cycle after bt_done.
//  6. clear_all, or reset_n=0, during BT_DRAIN -> state RUN, level 0, no bt_done; next push
//     lands @lvl0.

Source files
------------

// File: rtl/trail_access_ctrl_pkg.sv
// Shared types and constants for the trail access controller.
// Contents:
//   LVL_W / VAR_W / HEIGHT_W  widths of decision level, variable id, trail height
//   ctrl_state_t              controller FSM states
//   trail_push_t              one assignment as written into the trail
//   inc_level()               next decision level
package trail_access_ctrl_pkg;

    localparam int LVL_W    = 16;
    localparam int VAR_W    = 32;
    localparam int HEIGHT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BT_ISSUE = 2'd1,
        ST_BT_DRAIN = 2'd2,
        ST_BT_DONE  = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic [VAR_W-1:0] var_id;
        logic             value;
        logic [LVL_W-1:0] level;
        logic             is_decision;
        logic [LVL_W-1:0] reason;
    } trail_push_t;

    function automatic logic [LVL_W-1:0] inc_level(input logic [LVL_W-1:0] lvl);
        return lvl + LVL_W'(1);
    endfunction

endpackage

// File: rtl/trail_access_ctrl_if.sv
// Bundles for the trail access controller.
//   trail_req_if : push requesters + backtrack requester + clear stream.
//                  master = requester side, slave = controller side.
//   trail_tm_if  : controller <-> trail manager.
//                  master = controller side, slave = trail manager side.
interface trail_req_if
    import trail_access_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][VAR_W-1:0] req_var;
    logic [NUM_REQ-1:0]            req_value;
    logic [NUM_REQ-1:0]            req_is_decision;
    logic [NUM_REQ-1:0][LVL_W-1:0] req_reason;
    logic                          bt_req_valid;
    logic                          bt_req_ready;
    logic [LVL_W-1:0]              bt_req_level;
    logic                          bt_done;
    logic                          clr_valid;
    logic [VAR_W-1:0]              clr_var;
    logic                          clr_value;

    modport master (
        output req_valid, req_var, req_value, req_is_decision, req_reason,
               bt_req_valid, bt_req_level,
        input  req_ready, bt_req_ready, bt_done, clr_valid, clr_var, clr_value
    );

    modport slave (
        input  req_valid, req_var, req_value, req_is_decision, req_reason,
               bt_req_valid, bt_req_level,
        output req_ready, bt_req_ready, bt_done, clr_valid, clr_var, clr_value
    );
endinterface

interface trail_tm_if
    import trail_access_ctrl_pkg::*;
;
    logic                tm_push;
    logic [VAR_W-1:0]    tm_push_var;
    logic                tm_push_value;
    logic [LVL_W-1:0]    tm_push_level;
    logic                tm_push_is_decision;
    logic [LVL_W-1:0]    tm_push_reason;
    logic                tm_backtrack_en;
    logic [LVL_W-1:0]    tm_backtrack_to_level;
    logic                tm_backtrack_valid;
    logic [VAR_W-1:0]    tm_backtrack_var;
    logic                tm_backtrack_value;
    logic                tm_backtrack_done;
    logic [HEIGHT_W-1:0] tm_height;
    logic                tm_clear_all;

    modport master (
        output tm_push, tm_push_var, tm_push_value, tm_push_level, tm_push_is_decision,
               tm_push_reason, tm_backtrack_en, tm_backtrack_to_level, tm_clear_all,
        input  tm_backtrack_valid, tm_backtrack_var, tm_backtrack_value,
               tm_backtrack_done, tm_height
    );

    modport slave (
        input  tm_push, tm_push_var, tm_push_value, tm_push_level, tm_push_is_decision,
               tm_push_reason, tm_backtrack_en, tm_backtrack_to_level, tm_clear_all,
        output tm_backtrack_valid, tm_backtrack_var, tm_backtrack_value,
               tm_backtrack_done, tm_height
    );
endinterface

// File: rtl/trail_access_ctrl_prio_dec_arb.sv
// Fixed-priority push arbiter with decision masking (purely combinational).
// Ports:
//   en_i              grant allowed this cycle at all
//   dec_en_i          decisions may be granted (level not saturated)
//   req_valid_i       per-requester push request
//   req_is_decision_i per-requester decision flag
//   gnt_o             one-hot grant (all zero when nothing is granted)
// Lowest index wins among propagations; decisions compete only when no
// propagation is pending, so implied literals always land before a new level.
module trail_access_ctrl_prio_dec_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic               en_i,
    input  logic               dec_en_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [NUM_REQ-1:0] req_is_decision_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [NUM_REQ-1:0] prop_v_s;
    logic [NUM_REQ-1:0] dec_v_s;
    logic [NUM_REQ-1:0] cand_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic               taken_s;

    // Select candidate class, then keep only the lowest set bit.
    always_comb begin
        prop_v_s = req_valid_i & ~req_is_decision_i;
        dec_v_s  = req_valid_i & req_is_decision_i & {NUM_REQ{dec_en_i}};
        cand_s   = (|prop_v_s) ? prop_v_s : dec_v_s;
        gnt_s    = '0;
        taken_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_s[i] = en_i & cand_s[i] & ~taken_s;
            taken_s  = taken_s | cand_s[i];
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: rtl/trail_access_ctrl.sv
// Sole master of the trail manager's push and backtrack ports.
// Ports:
//   clk, reset_n  clock (rising edge), asynchronous active-low reset
//   clear_all     synchronous flush: level 0, back to RUN, drain abandoned
//   req_if        requester side (pushes, backtrack handshake, clear stream)
//   tm_if         trail manager side (push, backtrack command, drain stream)
//   level         current decision level
//   busy          backtrack in flight
//   trail_full    trail height has reached MAX_VARS
// Pushes are granted combinationally in RUN only; a backtrack request in the
// same cycle wins, and no push is accepted until the cycle after bt_done so
// the trail height has settled after the drain.
module trail_access_ctrl
    import trail_access_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_VARS = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_all,
    trail_req_if.slave       req_if,
    trail_tm_if.master       tm_if,
    output logic [LVL_W-1:0] level,
    output logic             busy,
    output logic             trail_full
);

    ctrl_state_t        state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   target_q, target_d;
    logic               noop_done_q, noop_done_d;

    logic               full_s;
    logic               arb_en_s;
    logic               dec_en_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic               push_s;
    logic               push_dec_s;
    trail_push_t        push_data_s;
    logic               bt_req_ready_s;
    logic               bt_done_s;
    logic               bt_en_s;
    logic [LVL_W-1:0]   bt_to_level_s;
    logic               clr_valid_s;
    logic [VAR_W-1:0]   clr_var_s;
    logic               clr_value_s;

    assign full_s   = (tm_if.tm_height >= HEIGHT_W'(MAX_VARS));
    assign arb_en_s = (state_q == ST_RUN) & ~clear_all & ~req_if.bt_req_valid & ~full_s;
    assign dec_en_s = (level_q != {LVL_W{1'b1}});

    trail_access_ctrl_prio_dec_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .en_i              (arb_en_s),
        .dec_en_i          (dec_en_s),
        .req_valid_i       (req_if.req_valid),
        .req_is_decision_i (req_if.req_is_decision),
        .gnt_o             (gnt_s)
    );

    // Mux the granted requester's fields onto the trail push port (AND-OR over the one-hot grant).
    always_comb begin
        push_data_s = '0;
        push_s      = |gnt_s;
        push_dec_s  = |(gnt_s & req_if.req_is_decision);
        for (int i = 0; i < NUM_REQ; i++) begin
            push_data_s.var_id      = push_data_s.var_id | ({VAR_W{gnt_s[i]}} & req_if.req_var[i]);
            push_data_s.value       = push_data_s.value | (gnt_s[i] & req_if.req_value[i]);
            push_data_s.is_decision = push_data_s.is_decision | (gnt_s[i] & req_if.req_is_decision[i]);
            // Reason is meaningless for decisions and is forced to zero.
            push_data_s.reason      = push_data_s.reason |
                ({LVL_W{gnt_s[i] & ~req_if.req_is_decision[i]}} & req_if.req_reason[i]);
        end
        push_data_s.level = push_s ? (push_dec_s ? inc_level(level_q) : level_q) : '0;
    end

    // Next-state, level bookkeeping and backtrack sequencing outputs.
    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        target_d       = target_q;
        noop_done_d    = 1'b0;
        bt_req_ready_s = 1'b0;
        bt_done_s      = 1'b0;
        bt_en_s        = 1'b0;
        bt_to_level_s  = '0;
        clr_valid_s    = 1'b0;
        clr_var_s      = '0;
        clr_value_s    = 1'b0;
        if (clear_all) begin
            state_d  = ST_RUN;
            level_d  = '0;
            target_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    bt_done_s = noop_done_q;
                    if (req_if.bt_req_valid) begin
                        bt_req_ready_s = 1'b1;
                        if (req_if.bt_req_level >= level_q) begin
                            noop_done_d = 1'b1;
                        end else begin
                            target_d = req_if.bt_req_level;
                            state_d  = ST_BT_ISSUE;
                        end
                    end else if (push_s && push_dec_s) begin
                        level_d = inc_level(level_q);
                    end else begin
                        level_d = level_q;
                    end
                end
                ST_BT_ISSUE: begin
                    bt_en_s       = 1'b1;
                    bt_to_level_s = target_q;
                    state_d       = ST_BT_DRAIN;
                end
                ST_BT_DRAIN: begin
                    clr_valid_s = tm_if.tm_backtrack_valid;
                    clr_var_s   = tm_if.tm_backtrack_var;
                    clr_value_s = tm_if.tm_backtrack_value;
                    if (tm_if.tm_backtrack_done) begin
                        state_d = ST_BT_DONE;
                    end else begin
                        state_d = ST_BT_DRAIN;
                    end
                end
                ST_BT_DONE: begin
                    level_d   = target_q;
                    bt_done_s = 1'b1;
                    state_d   = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    level_d = '0;
                end
            endcase
        end
    end

    // State, level, backtrack target and no-op completion registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            level_q     <= '0;
            target_q    <= '0;
            noop_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            target_q    <= target_d;
            noop_done_q <= noop_done_d;
        end
    end

    assign req_if.req_ready             = gnt_s;
    assign req_if.bt_req_ready          = bt_req_ready_s;
    assign req_if.bt_done               = bt_done_s;
    assign req_if.clr_valid             = clr_valid_s;
    assign req_if.clr_var               = clr_var_s;
    assign req_if.clr_value             = clr_value_s;

    assign tm_if.tm_push                = push_s;
    assign tm_if.tm_push_var            = push_data_s.var_id;
    assign tm_if.tm_push_value          = push_data_s.value;
    assign tm_if.tm_push_level          = push_data_s.level;
    assign tm_if.tm_push_is_decision    = push_data_s.is_decision;
    assign tm_if.tm_push_reason         = push_data_s.reason;
    assign tm_if.tm_backtrack_en        = bt_en_s;
    assign tm_if.tm_backtrack_to_level  = bt_to_level_s;
    assign tm_if.tm_clear_all           = clear_all;

    assign level      = level_q;
    assign busy       = (state_q != ST_RUN);
    assign trail_full = full_s;

endmodule

// File: tb/tb_trail_access_ctrl.sv
module tb_trail_access_ctrl;
    import trail_access_ctrl_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        clear_all;
    logic [15:0] level;
    logic        busy;
    logic        trail_full;

    int n_checks = 0;
    int n_errors = 0;

    trail_req_if #(.NUM_REQ(2)) rq ();
    trail_tm_if                 tm ();

    trail_access_ctrl #(
        .NUM_REQ  (2),
        .MAX_VARS (256)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_all  (clear_all),
        .req_if     (rq),
        .tm_if      (tm),
        .level      (level),
        .busy       (busy),
        .trail_full (trail_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural trail manager: stack of pushed entries, drains entries above target.
    logic [31:0] m_var [0:511];
    logic        m_val [0:511];
    logic [15:0] m_lvl [0:511];
    logic [15:0] m_h;
    logic        m_drain;
    logic [15:0] m_tgt;
    logic [8:0]  m_top;

    assign m_top                 = m_h[8:0] - 9'd1;
    assign tm.tm_height          = m_h;
    assign tm.tm_backtrack_valid = m_drain && (m_h != 16'd0) && (m_lvl[m_top] > m_tgt);
    assign tm.tm_backtrack_var   = tm.tm_backtrack_valid ? m_var[m_top] : 32'd0;
    assign tm.tm_backtrack_value = tm.tm_backtrack_valid ? m_val[m_top] : 1'b0;
    assign tm.tm_backtrack_done  = m_drain && !tm.tm_backtrack_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_h     <= 16'd0;
            m_drain <= 1'b0;
            m_tgt   <= 16'd0;
        end else if (tm.tm_clear_all) begin
            m_h     <= 16'd0;
            m_drain <= 1'b0;
        end else begin
            if (tm.tm_push) begin
                m_var[m_h[8:0]] <= tm.tm_push_var;
                m_val[m_h[8:0]] <= tm.tm_push_value;
                m_lvl[m_h[8:0]] <= tm.tm_push_level;
                m_h             <= m_h + 16'd1;
            end
            if (tm.tm_backtrack_en) begin
                m_drain <= 1'b1;
                m_tgt   <= tm.tm_backtrack_to_level;
            end else if (m_drain && tm.tm_backtrack_valid) begin
                m_h <= m_h - 16'd1;
            end else if (m_drain) begin
                m_drain <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rq.req_valid       = 2'b00;
        rq.req_is_decision = 2'b00;
        rq.req_value       = 2'b00;
        rq.req_var[0]      = 32'd0;
        rq.req_var[1]      = 32'd0;
        rq.req_reason[0]   = 16'hA000;
        rq.req_reason[1]   = 16'hB001;
        rq.bt_req_valid    = 1'b0;
        rq.bt_req_level    = 16'd0;
    endtask

    // One push through requester idx; checks the trail write level.
    task automatic push_one(input int idx, input logic [31:0] v, input logic dec,
                            input logic [15:0] exp_lvl);
        rq.req_valid            = 2'b00;
        rq.req_is_decision      = 2'b00;
        rq.req_valid[idx]       = 1'b1;
        rq.req_is_decision[idx] = dec;
        rq.req_var[idx]         = v;
        @(negedge clk);
        chk("push_one_push", tm.tm_push, 1'b1);
        chk("push_one_var", tm.tm_push_var, v);
        chk("push_one_lvl", tm.tm_push_level, exp_lvl);
        @(posedge clk); #1;
        rq.req_valid       = 2'b00;
        rq.req_is_decision = 2'b00;
    endtask

    // Observe a backtrack from BT_ISSUE until bt_done; ends one cycle after bt_done.
    task automatic run_drain(output int n_beats, output logic [95:0] beats, output int en_cnt,
                             output logic [15:0] en_lvl, output int push_seen, output logic ok);
        logic done;
        n_beats = 0; beats = 96'd0; en_cnt = 0; en_lvl = 16'd0; push_seen = 0; ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (tm.tm_backtrack_en) begin
                en_cnt++;
                en_lvl = tm.tm_backtrack_to_level;
            end
            if (rq.clr_valid) begin
                if (n_beats < 3) beats[n_beats*32 +: 32] = rq.clr_var;
                n_beats++;
            end
            if (tm.tm_push || (|rq.req_ready)) push_seen++;
            done = rq.bt_done;
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        clear_all = 1'b1;
        @(negedge clk);
        chk("tm_clear_all_copy", tm.tm_clear_all, 1'b1);
        @(posedge clk); #1;
        clear_all = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  dec;
        logic [1:0]  val;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [1:0]  e_ready;
        logic        e_push;
        logic [31:0] e_var;
        logic        e_value;
        logic [15:0] e_lvl;
        logic [15:0] e_reason;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          nb, ec, ps, cnt;
        logic [95:0] bt;
        logic [15:0] el;
        logic        ok;
        logic        bad;

        vecs[0] = '{2'b11, 2'b10, 2'b01, 32'd5,  32'd9,  2'b01, 1'b1, 32'd5,  1'b1, 16'd0, 16'hA000};
        vecs[1] = '{2'b10, 2'b10, 2'b10, 32'd0,  32'd9,  2'b10, 1'b1, 32'd9,  1'b1, 16'd1, 16'h0000};
        vecs[2] = '{2'b11, 2'b11, 2'b00, 32'd20, 32'd21, 2'b01, 1'b1, 32'd20, 1'b0, 16'd2, 16'h0000};
        vecs[3] = '{2'b11, 2'b00, 2'b10, 32'd30, 32'd31, 2'b01, 1'b1, 32'd30, 1'b0, 16'd2, 16'hA000};
        vecs[4] = '{2'b10, 2'b00, 2'b10, 32'd0,  32'd31, 2'b10, 1'b1, 32'd31, 1'b1, 16'd2, 16'hB001};
        vecs[5] = '{2'b00, 2'b00, 2'b00, 32'd0,  32'd0,  2'b00, 1'b0, 32'd0,  1'b0, 16'd0, 16'h0000};
        vecs[6] = '{2'b01, 2'b01, 2'b01, 32'd40, 32'd0,  2'b01, 1'b1, 32'd40, 1'b1, 16'd3, 16'h0000};
        vecs[7] = '{2'b11, 2'b01, 2'b10, 32'd41, 32'd42, 2'b10, 1'b1, 32'd42, 1'b1, 16'd3, 16'hB001};

        idle_inputs();
        clear_all = 1'b0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_level", level, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bt_req_ready", rq.bt_req_ready, 1'b0);
        chk("rst_bt_done", rq.bt_done, 1'b0);
        chk("rst_tm_push", tm.tm_push, 1'b0);
        chk("rst_tm_bt_en", tm.tm_backtrack_en, 1'b0);
        chk("rst_clr_valid", rq.clr_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Arbitration / level table.
        for (int i = 0; i < 8; i++) begin
            rq.req_valid       = vecs[i].valid;
            rq.req_is_decision = vecs[i].dec;
            rq.req_value       = vecs[i].val;
            rq.req_var[0]      = vecs[i].v0;
            rq.req_var[1]      = vecs[i].v1;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), rq.req_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d_push", i), tm.tm_push, vecs[i].e_push);
            chk($sformatf("vec%0d_var", i), tm.tm_push_var, vecs[i].e_var);
            chk($sformatf("vec%0d_value", i), tm.tm_push_value, vecs[i].e_value);
            chk($sformatf("vec%0d_lvl", i), tm.tm_push_level, vecs[i].e_lvl);
            chk($sformatf("vec%0d_reason", i), tm.tm_push_reason, vecs[i].e_reason);
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        chk("table_level", level, 16'd3);
        @(posedge clk); #1;

        // Backtrack from level 3 to 1 drains 4,3,2.
        pulse_clear();
        @(negedge clk);
        chk("clear_level", level, 16'd0);
        @(posedge clk); #1;
        push_one(0, 32'd1, 1'b1, 16'd1);
        push_one(0, 32'd2, 1'b1, 16'd2);
        push_one(1, 32'd3, 1'b1, 16'd3);
        push_one(1, 32'd4, 1'b0, 16'd3);
        rq.bt_req_valid = 1'b1;
        rq.bt_req_level = 16'd1;
        @(negedge clk);
        chk("bt2_req_ready", rq.bt_req_ready, 1'b1);
        chk("bt2_busy_before", busy, 1'b0);
        @(posedge clk); #1;
        rq.bt_req_valid = 1'b0;
        run_drain(nb, bt, ec, el, ps, ok);
        chk("bt2_timeout", ok, 1'b1);
        chk("bt2_en_count", ec, 1);
        chk("bt2_en_level", el, 16'd1);
        chk("bt2_beats", nb, 3);
        chk("bt2_stream", bt, {32'd2, 32'd3, 32'd4});
        @(negedge clk);
        chk("bt2_level", level, 16'd1);
        chk("bt2_busy_after", busy, 1'b0);
        chk("bt2_done_one_cycle", rq.bt_done, 1'b0);
        @(posedge clk); #1;

        // No-op backtrack: target above the current level.
        push_one(0, 32'd7, 1'b1, 16'd2);
        rq.bt_req_valid = 1'b1;
        rq.bt_req_level = 16'd3;
        @(negedge clk);
        chk("noop_req_ready", rq.bt_req_ready, 1'b1);
        @(posedge clk); #1;
        rq.bt_req_valid = 1'b0;
        @(negedge clk);
        chk("noop_done", rq.bt_done, 1'b1);
        chk("noop_no_bt_en", tm.tm_backtrack_en, 1'b0);
        chk("noop_level", level, 16'd2);
        chk("noop_busy", busy, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("noop_done_cleared", rq.bt_done, 1'b0);
        @(posedge clk); #1;

        // Backtrack and push in the same cycle: backtrack wins, push waits.
        rq.req_valid[0]       = 1'b1;
        rq.req_is_decision[0] = 1'b0;
        rq.req_var[0]         = 32'd50;
        rq.bt_req_valid       = 1'b1;
        rq.bt_req_level       = 16'd0;
        @(negedge clk);
        chk("race_bt_ready", rq.bt_req_ready, 1'b1);
        chk("race_req_ready", rq.req_ready, 2'b00);
        chk("race_no_push", tm.tm_push, 1'b0);
        @(posedge clk); #1;
        rq.bt_req_valid = 1'b0;
        run_drain(nb, bt, ec, el, ps, ok);
        chk("race_timeout", ok, 1'b1);
        chk("race_beats", nb, 2);
        chk("race_stream", bt, {32'd0, 32'd1, 32'd7});
        chk("race_push_during_bt", ps, 0);
        @(negedge clk);
        chk("race_push_after", tm.tm_push, 1'b1);
        chk("race_push_var", tm.tm_push_var, 32'd50);
        chk("race_push_lvl", tm.tm_push_level, 16'd0);
        @(posedge clk); #1;
        idle_inputs();

        // Fill the trail, hold a request while full, free it with a backtrack.
        pulse_clear();
        push_one(0, 32'd100, 1'b1, 16'd1);
        rq.req_valid[0] = 1'b1;
        rq.req_var[0]   = 32'd200;
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!rq.req_ready[0]) break;
            cnt++;
            @(posedge clk); #1;
        end
        chk("fill_count", cnt, 255);
        chk("full_flag", trail_full, 1'b1);
        chk("full_ready", rq.req_ready, 2'b00);
        chk("full_no_push", tm.tm_push, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_held", rq.req_ready, 2'b00);
        @(posedge clk); #1;
        rq.bt_req_valid = 1'b1;
        rq.bt_req_level = 16'd0;
        @(negedge clk);
        chk("full_bt_ready", rq.bt_req_ready, 1'b1);
        @(posedge clk); #1;
        rq.bt_req_valid = 1'b0;
        run_drain(nb, bt, ec, el, ps, ok);
        chk("full_bt_timeout", ok, 1'b1);
        chk("full_bt_beats", nb, 256);
        chk("full_bt_no_push", ps, 0);
        @(negedge clk);
        chk("full_regrant", tm.tm_push, 1'b1);
        chk("full_regrant_var", tm.tm_push_var, 32'd200);
        chk("full_regrant_lvl", tm.tm_push_level, 16'd0);
        chk("full_cleared", trail_full, 1'b0);
        @(posedge clk); #1;
        idle_inputs();

        // clear_all during the drain.
        pulse_clear();
        push_one(0, 32'd1, 1'b1, 16'd1);
        push_one(0, 32'd2, 1'b1, 16'd2);
        push_one(0, 32'd3, 1'b0, 16'd2);
        rq.bt_req_valid = 1'b1;
        rq.bt_req_level = 16'd0;
        @(posedge clk); #1;
        rq.bt_req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr_in_drain", rq.clr_valid, 1'b1);
        @(posedge clk); #1;
        clear_all = 1'b1;
        @(negedge clk);
        chk("clr_abort_no_done", rq.bt_done, 1'b0);
        chk("clr_abort_no_clr", rq.clr_valid, 1'b0);
        @(posedge clk); #1;
        clear_all = 1'b0;
        @(negedge clk);
        chk("clr_abort_level", level, 16'd0);
        chk("clr_abort_busy", busy, 1'b0);
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rq.bt_done || tm.tm_backtrack_en) bad = 1'b1;
        end
        chk("clr_abort_quiet", bad, 1'b0);
        @(posedge clk); #1;
        push_one(0, 32'd60, 1'b0, 16'd0);

        // Asynchronous reset during the drain.
        push_one(1, 32'd1, 1'b1, 16'd1);
        push_one(1, 32'd2, 1'b1, 16'd2);
        rq.bt_req_valid = 1'b1;
        rq.bt_req_level = 16'd0;
        @(posedge clk); #1;
        rq.bt_req_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_abort_level", level, 16'd0);
        chk("rst_abort_busy", busy, 1'b0);
        chk("rst_abort_clr", rq.clr_valid, 1'b0);
        chk("rst_abort_done", rq.bt_done, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rq.bt_done || busy) bad = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst_abort_quiet", bad, 1'b0);
        push_one(0, 32'd61, 1'b0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
